// File: rtl/fpu_add_arbiter_pkg.sv
// Shared definitions for the two-requester FADD arbiter: op encodings, FP field positions, FSM states.
package fpu_add_arbiter_pkg;

    typedef enum logic {
        FADD = 1'b0,
        FSUB = 1'b1
    } fp_op_t;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Denormals are not special: only an all-zero exponent and mantissa counts as zero.
    function automatic logic fp_is_zero(input logic [31:0] v);
        return {v[EXP_MSB:EXP_LSB], v[MAN_MSB:0]} == '0;
    endfunction

endpackage

// File: rtl/fpu_add_arbiter_if.sv
// Issue/response bus of the FADD arbiter plus the wires to the shared adder datapath.
interface fpu_add_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_sub;
    logic [31:0] req0_op1;
    logic [31:0] req0_op2;
    logic [31:0] req1_op1;
    logic [31:0] req1_op2;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp0_data;
    logic [31:0] resp1_data;
    logic        busy;
    logic        adder_op;
    logic [31:0] adder_a;
    logic [31:0] adder_b;
    logic [31:0] adder_result;

    modport master (
        output req_valid, req_sub, req0_op1, req0_op2, req1_op1, req1_op2,
               resp_ready, adder_result,
        input  req_ready, resp_valid, resp0_data, resp1_data, busy,
               adder_op, adder_a, adder_b
    );

    modport slave (
        input  req_valid, req_sub, req0_op1, req0_op2, req1_op1, req1_op2,
               resp_ready, adder_result,
        output req_ready, resp_valid, resp0_data, resp1_data, busy,
               adder_op, adder_a, adder_b
    );
endinterface

// File: rtl/fpu_rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant while enabled,
// pointer moves to the other requester whenever a grant is issued.
module fpu_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    logic rr_ptr;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (elig == 2'b11) begin
                grant = rr_ptr ? 2'b10 : 2'b01;
            end else begin
                grant = elig;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (grant[0]) begin
            rr_ptr <= 1'b1;
        end else if (grant[1]) begin
            rr_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one combinational FP adder between two requesters; result registered EXEC_CYCLES+1 edges after accept.
// A held response only blocks its own requester; zero operands bypass the adder.
module fpu_add_arbiter
    import fpu_add_arbiter_pkg::*;
#(
    parameter int EXEC_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    fpu_add_arbiter_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              owner;
    logic              a_zero;
    logic              b_zero;
    logic [1:0]        elig;
    logic [1:0]        grant;
    logic              accept;
    logic              sel;
    logic [31:0]       sel_op1;
    logic [31:0]       sel_op2;
    logic [31:0]       b_eff;
    logic [31:0]       wb_result;
    logic [31:0]       adder_a_q;
    logic [31:0]       adder_b_q;
    logic [1:0]        resp_valid_q;
    logic [31:0]       resp_data_q [2];

    // A requester whose response is still held may only reissue if that response drains this cycle.
    assign elig = bus.req_valid & (~resp_valid_q | bus.resp_ready);

    fpu_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_IDLE),
        .elig  (elig),
        .grant (grant)
    );

    assign accept = |grant;
    assign sel    = grant[1];

    always_comb begin
        sel_op1         = sel ? bus.req1_op1 : bus.req0_op1;
        sel_op2         = sel ? bus.req1_op2 : bus.req0_op2;
        b_eff           = sel_op2;
        b_eff[SIGN_BIT] = sel_op2[SIGN_BIT] ^ bus.req_sub[sel];
    end

    // The adder assumes a hidden bit, so zero operands are resolved here instead.
    always_comb begin
        if (a_zero && b_zero) begin
            wb_result = {adder_a_q[SIGN_BIT] & adder_b_q[SIGN_BIT], 31'b0};
        end else if (a_zero) begin
            wb_result = adder_b_q;
        end else if (b_zero) begin
            wb_result = adder_a_q;
        end else begin
            wb_result = bus.adder_result;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: if (cnt == '0) state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            owner        <= 1'b0;
            a_zero       <= 1'b0;
            b_zero       <= 1'b0;
            adder_a_q    <= '0;
            adder_b_q    <= '0;
            resp_valid_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                resp_data_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                adder_a_q <= sel_op1;
                adder_b_q <= b_eff;
                owner     <= sel;
                a_zero    <= fp_is_zero(sel_op1);
                b_zero    <= fp_is_zero(sel_op2);
                cnt       <= CNT_W'(EXEC_CYCLES - 1);
            end else if (state == ST_EXEC && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            // A write-back to the same requester wins over a consume on the same edge.
            for (int i = 0; i < 2; i++) begin
                if (state == ST_WB && owner == 1'(i)) begin
                    resp_valid_q[i] <= 1'b1;
                    resp_data_q[i]  <= wb_result;
                end else if (bus.resp_ready[i]) begin
                    resp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp0_data = resp_data_q[0];
    assign bus.resp1_data = resp_data_q[1];
    assign bus.busy       = (state != ST_IDLE);
    assign bus.adder_op   = FADD;
    assign bus.adder_a    = adder_a_q;
    assign bus.adder_b    = adder_b_q;

endmodule
